// File: rtl/full_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
// Holds the default operand width and a helper for the carry-chain length.
package full_adder_pkg;

    localparam int unsigned FaDefaultWidth = 1;

    // The carry chain has one more node than there are cells.
    function automatic int unsigned fa_chain_len(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder.
// The master drives operands and the enable; the slave (the adder) drives the results.
interface full_adder_if
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = FaDefaultWidth
) ();

    logic             en;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic [WIDTH-1:0] S_r;
    logic             Cout_r;

    modport master (
        output en, A, B, Cin,
        input  S, Cout, S_r, Cout_r
    );

    modport slave (
        input  en, A, B, Cin,
        output S, Cout, S_r, Cout_r
    );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell; the leaf of the ripple-carry chain.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_p;

    assign w_p    = i_a ^ i_b;
    assign o_s    = w_p ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a zero-latency result and a registered copy.
// Only the registered copy sees the clock, enable and asynchronous reset.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = FaDefaultWidth
) (
    input  logic          clk,
    input  logic          rst_n,
    full_adder_if.slave   bus
);

    localparam int unsigned ChainLen = fa_chain_len(WIDTH);

    logic [ChainLen-1:0] w_carry;
    logic [WIDTH-1:0]    w_sum;
    logic [WIDTH-1:0]    r_s;
    logic                r_cout;

    assign w_carry[0] = bus.Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .i_a    (bus.A[i]),
            .i_b    (bus.B[i]),
            .i_cin  (w_carry[i]),
            .o_s    (w_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    assign bus.S    = w_sum;
    assign bus.Cout = w_carry[ChainLen-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else if (bus.en) begin
            r_s    <= w_sum;
            r_cout <= w_carry[ChainLen-1];
        end
    end

    assign bus.S_r    = r_s;
    assign bus.Cout_r = r_cout;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 (exhaustive) and WIDTH=8 (directed + random).
module tb_full_adder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    full_adder_if #(.WIDTH(1)) bus1 ();
    full_adder_if #(.WIDTH(8)) bus8 ();

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] s_tab;
        logic [7:0] c_tab;
        logic [2:0] vec;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       ren;
        logic [8:0] sum;
        logic [8:0] reg_exp;

        checks  = 0;
        errors  = 0;
        // Required truth table for inputs 000..111, bit i = row i.
        s_tab   = 8'b1001_0110;
        c_tab   = 8'b1110_1000;

        rst_n   = 1'b0;
        bus1.en = 1'b0; bus1.A = '0; bus1.B = '0; bus1.Cin = 1'b0;
        bus8.en = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
        #1;
        check("reset_w1_reg", {7'd0, bus1.Cout_r, bus1.S_r}, 9'd0);
        check("reset_w8_reg", {bus8.Cout_r, bus8.S_r}, 9'd0);
        check("zero_w8_comb", {bus8.Cout, bus8.S}, 9'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive, 100-unit spacing.
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {bus1.A, bus1.B, bus1.Cin} = vec;
            #100;
            check($sformatf("w1_S_%0d", i), {8'd0, bus1.S}, {8'd0, s_tab[i]});
            check($sformatf("w1_Cout_%0d", i), {8'd0, bus1.Cout}, {8'd0, c_tab[i]});
        end

        // Registered capture and hold.
        @(negedge clk);
        bus1.A = 1'b1; bus1.B = 1'b1; bus1.Cin = 1'b1; bus1.en = 1'b1;
        @(posedge clk); #1;
        check("w1_reg_capture", {7'd0, bus1.Cout_r, bus1.S_r}, 9'b11);
        @(negedge clk);
        bus1.en = 1'b0; bus1.A = 1'b0; bus1.B = 1'b0; bus1.Cin = 1'b0;
        @(posedge clk); #1;
        check("w1_reg_hold", {7'd0, bus1.Cout_r, bus1.S_r}, 9'b11);
        check("w1_comb_after_hold", {7'd0, bus1.Cout, bus1.S}, 9'b00);

        // Asynchronous reset between edges, with en high so reset must dominate.
        @(negedge clk);
        bus1.en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("w1_async_reset", {7'd0, bus1.Cout_r, bus1.S_r}, 9'd0);
        bus1.A = 1'b1; bus1.B = 1'b0; bus1.Cin = 1'b0;
        #1;
        check("w1_comb_in_reset", {7'd0, bus1.Cout, bus1.S}, 9'b01);
        @(posedge clk); #1;
        check("w1_reset_dominates_en", {7'd0, bus1.Cout_r, bus1.S_r}, 9'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        bus1.en = 1'b0;

        // WIDTH=8 boundaries.
        bus8.A = 8'hFF; bus8.B = 8'h00; bus8.Cin = 1'b1;
        #1;
        check("w8_ripple", {bus8.Cout, bus8.S}, 9'h100);
        bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.Cin = 1'b1;
        #1;
        check("w8_max", {bus8.Cout, bus8.S}, 9'h1FF);
        bus8.A = 8'h00; bus8.B = 8'h00; bus8.Cin = 1'b0;
        #1;
        check("w8_zero", {bus8.Cout, bus8.S}, 9'h000);

        // WIDTH=8 random against plain 9-bit arithmetic; en toggled to exercise hold.
        reg_exp = {bus8.Cout_r, bus8.S_r} === 9'd0 ? 9'd0 : 9'h1XX;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            ren = ($urandom_range(3) != 0);
            bus8.A = ra; bus8.B = rb; bus8.Cin = rc; bus8.en = ren;
            sum = 9'(ra) + 9'(rb) + 9'(rc);
            #1;
            check("w8_rand_comb", {bus8.Cout, bus8.S}, sum);
            if (ren) reg_exp = sum;
            @(posedge clk); #1;
            check("w8_rand_reg", {bus8.Cout_r, bus8.S_r}, reg_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
